scan_chain_target: RTL and testbench
====================================

Name: scan_chain_target

Overview:
- Responder end of the scan protocol. Sits beside a block of functional state and implements the scan chain that the scan controller drives.
- On a scan session it captures the functional state into a shadow shift register and shifts it out LSB-first on scan_output, while shifting scan_input in.
- On a correctly sized session it writes the shifted-in image back to the functional registers. This gives snapshot/restore of hardware state.

Parameters:
- CHAIN_LEN, 64, number of scannable bits (1..4096).
- CNT_W, $clog2(CHAIN_LEN+2), shifted-bit counter width; derived, do not override.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-high.
- scan_enable  in  1  session active (level).
- scan_ck_enable  in  1  one-cycle shift strobe.
- scan_input  in  1  serial data from controller.
- scan_output  out  1  serial data to controller; equals shadow[0], combinational from register.
- func_state_in  in  CHAIN_LEN  live functional state to capture.
- func_state_out  out  CHAIN_LEN  restored state image (registered).
- func_load  out  1  one-cycle pulse: functional block loads func_state_out.
- func_hold  out  1  freeze functional logic during session.
- bit_count  out  CNT_W  bits shifted this session.
- len_err  out  1  sticky: last session length != CHAIN_LEN.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, shadow=0, func_state_out=0, func_load=0, func_hold=0, bit_count=0, len_err=0. Reset mid-session aborts with no load pulse.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - scan_ck_enable is ignored.
  - If scan_enable=1 at an edge: shadow<=func_state_in, bit_count<=0, go to SHIFT. Capture takes exactly 1 cycle.
  - scan_output therefore shows func_state_in[0] the cycle after scan_enable is first seen high, before the first strobe.
- SHIFT:
  - func_hold=1.
  - On scan_ck_enable=1: shadow<={scan_input, shadow[CHAIN_LEN-1:1]}; bit_count<=bit_count+1, saturating at all-ones.
  - When scan_enable=0:
    - if the effective count == CHAIN_LEN: func_state_out<=shadow (post-shift), len_err<=0, go to UPDATE;
    - otherwise: len_err<=1, go to IDLE; func_state_out unchanged, no func_load.
- Simultaneous events: scan_ck_enable=1 with scan_enable=0 in the same cycle. The shift is applied first, and the length comparison uses the incremented count.
- UPDATE: func_load=1 and func_hold=1 for exactly one cycle, then IDLE.
- func_hold deasserts the cycle after UPDATE, or immediately on an aborted session.
- len_err stays set until the next correctly sized session or reset. bit_count holds its last value in IDLE until the next capture.
- Bit order matches the controller: the first bit shifted in lands in shadow[0] after CHAIN_LEN shifts. Shifting N words back unchanged restores the state exactly.
- A session with zero strobes gives a mismatch (CHAIN_LEN>=1), so there is no load.
- Latency from the final strobe to func_load: 1 cycle after scan_enable falls.

Optional Feature:
- Macro: SCAN_PARITY_EN.
- Defined:
  - The chain is CHAIN_LEN+1 bits. The extra MSB-side bit is even parity over the functional bits.
  - On capture, the parity bit = ^func_state_in, placed after bit CHAIN_LEN-1 in the output order.
  - The expected length becomes CHAIN_LEN+1.
  - On exit with the correct length, if the parity of the received bits mismatches: no update, parity_err (extra 1-bit output, sticky, same clear rule as len_err) <=1, go to IDLE.
- Undefined: no parity bit, no parity_err port; behaviour as above.

Decomposition:
- Package scan_pkg:
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, UPDATE=2'd2);
  - function for CNT_W;
  - parity helper function.
- One sub-module, scan_shadow_reg:
  - parallel load / serial shift register with width parameter, load, shift and serial-in controls;
  - provides serial-out and parallel-out.
- FSM, counter and error logic stay in the top.

Test Plan:
- CHAIN_LEN=8, func_state_in=8'hA5, scan_enable high, 8 strobes with scan_input=8'h3C LSB-first, then scan_enable low -> scan_output sequence 1,0,1,0,0,1,0,1; func_state_out=8'h3C; func_load high exactly 1 cycle; len_err=0.
- Same setup but 7 strobes -> no func_load, func_state_out unchanged, len_err=1, bit_count=7. Next correct 8-strobe session clears len_err.
- Last strobe coincides with scan_enable falling -> counted; update occurs with the 8th bit included.
- aresetn pulsed after 4 strobes -> all outputs 0 immediately, state IDLE, no func_load. A following session works normally.
- scan_ck_enable toggled in IDLE -> shadow, bit_count and scan_output unchanged.
- SCAN_PARITY_EN, CHAIN_LEN=8:
  - 9 strobes, correct parity -> load;
  - flipped parity bit -> parity_err=1, no load.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain target.
//   scan_state_e : FSM state encoding (IDLE / SHIFT / UPDATE)
//   scan_cnt_w   : width of the shifted-bit counter for a given chain length
//   parity_of    : even-parity helper over a zero-extended vector
// Optional build macro SCAN_PARITY_EN adds one parity bit to the chain, so the
// counter must also hold CHAIN_LEN+1 plus a saturation value.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } scan_state_e;

  localparam int PAR_W = 4097;

  function automatic int scan_cnt_w(input int chain_len);
`ifdef SCAN_PARITY_EN
    return $clog2(chain_len + 3);
`else
    return $clog2(chain_len + 2);
`endif
  endfunction

  function automatic logic parity_of(input logic [PAR_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/scan_chain_target_if.sv
// Serial scan link between the scan controller (master) and a target (slave).
//   scan_enable    : session active (level), driven by controller
//   scan_ck_enable : one-cycle shift strobe, driven by controller
//   scan_input     : serial data controller -> target
//   scan_output    : serial data target -> controller
interface scan_chain_target_if;
  logic scan_enable;
  logic scan_ck_enable;
  logic scan_input;
  logic scan_output;

  modport master (
    output scan_enable, scan_ck_enable, scan_input,
    input  scan_output
  );

  modport slave (
    input  scan_enable, scan_ck_enable, scan_input,
    output scan_output
  );
endinterface

// File: rtl/scan_shadow_reg.sv
// Parallel-load / serial-shift shadow register.
//   aclk, aresetn : clock, asynchronous active-high reset (clears to 0)
//   load          : capture load_data (has priority over shift)
//   shift         : shift right by one, serial_in entering at the MSB
//   serial_out    : bit 0 of the register
//   par_out       : full register contents
module scan_shadow_reg #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             load,
  input  logic             shift,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic [WIDTH-1:0] par_out
);

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      par_out <= '0;
    end else if (load) begin
      par_out <= load_data;
    end else if (shift) begin
      // written as a shifted concatenation so WIDTH=1 needs no special case
      par_out <= WIDTH'({serial_in, par_out} >> 1);
    end
  end

  assign serial_out = par_out[0];

endmodule

// File: rtl/scan_chain_target.sv
// Responder end of the scan chain: captures func_state_in into a shadow
// register, shifts it out LSB-first while shifting new data in, and on a
// correctly sized session writes the received image to func_state_out with a
// one-cycle func_load pulse.
//   aclk, aresetn    : clock, asynchronous active-high reset
//   scan             : scan link (slave modport)
//   func_state_in    : live functional state to capture
//   func_state_out   : restored state image (registered)
//   func_load        : one-cycle load pulse for the functional block
//   func_hold        : freeze functional logic while a session is active
//   bit_count        : strobes seen this session (saturating, held in IDLE)
//   len_err          : sticky, last session length was wrong
//   parity_err       : (SCAN_PARITY_EN only) sticky, received parity wrong
//   busy             : FSM not idle
// Build macro SCAN_PARITY_EN appends an even-parity bit above the MSB.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for scan_enable; strobes ignored
// ST_SHIFT  | session active, shifting on each strobe, functional hold
// ST_UPDATE | one cycle: func_load pulse after a valid session
module scan_chain_target
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = scan_cnt_w(CHAIN_LEN)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  scan_chain_target_if.slave   scan,
  input  logic [CHAIN_LEN-1:0] func_state_in,
  output logic [CHAIN_LEN-1:0] func_state_out,
  output logic                 func_load,
  output logic                 func_hold,
  output logic [CNT_W-1:0]     bit_count,
  output logic                 len_err,
`ifdef SCAN_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

`ifdef SCAN_PARITY_EN
  localparam int SH_W = CHAIN_LEN + 1;
`else
  localparam int SH_W = CHAIN_LEN;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_LEN = CNT_W'(SH_W);

  scan_state_e state, state_nx;

  logic            capture;
  logic            shift;
  logic            session_end;
  logic            len_ok;
  logic            img_ok;
  logic            accept;
  logic [SH_W-1:0] cap_data;
  logic [SH_W-1:0] shadow_q;
  logic [SH_W-1:0] shadow_nx;
  logic [CNT_W-1:0] cnt_nx;

`ifdef SCAN_PARITY_EN
  assign cap_data = {parity_of(PAR_W'(func_state_in)), func_state_in};
  // data plus its even-parity bit must XOR to zero
  assign img_ok   = ~parity_of(PAR_W'(shadow_nx));
`else
  assign cap_data = func_state_in;
  assign img_ok   = 1'b1;
`endif

  assign capture     = (state == ST_IDLE) && scan.scan_enable;
  assign shift       = (state == ST_SHIFT) && scan.scan_ck_enable;
  assign session_end = (state == ST_SHIFT) && !scan.scan_enable;

  // A strobe coinciding with scan_enable falling is counted and shifted
  // before the length check, so both use the post-shift view.
  assign cnt_nx    = (shift && (bit_count != CNT_MAX)) ? bit_count + 1'b1 : bit_count;
  assign shadow_nx = shift ? SH_W'({scan.scan_input, shadow_q} >> 1) : shadow_q;
  assign len_ok    = (cnt_nx == EXP_LEN);
  assign accept    = len_ok && img_ok;

  scan_shadow_reg #(.WIDTH(SH_W)) u_shadow (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (capture),
    .shift     (shift),
    .serial_in (scan.scan_input),
    .load_data (cap_data),
    .serial_out(scan.scan_output),
    .par_out   (shadow_q)
  );

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (scan.scan_enable) state_nx = ST_SHIFT;
      ST_SHIFT:  if (!scan.scan_enable) state_nx = accept ? ST_UPDATE : ST_IDLE;
      ST_UPDATE: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      bit_count      <= '0;
      len_err        <= 1'b0;
      func_state_out <= '0;
`ifdef SCAN_PARITY_EN
      parity_err     <= 1'b0;
`endif
    end else begin
      bit_count <= capture ? '0 : cnt_nx;
      if (session_end) begin
        len_err <= !len_ok;
`ifdef SCAN_PARITY_EN
        if (len_ok) parity_err <= !img_ok;
`endif
        if (accept) func_state_out <= shadow_nx[CHAIN_LEN-1:0];
      end
    end
  end

  assign func_load = (state == ST_UPDATE);
  assign func_hold = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_scan_chain_target.sv
module tb_scan_chain_target;
  import scan_pkg::*;

  localparam int L     = 8;
  localparam int CNT_W = scan_cnt_w(L);
`ifdef SCAN_PARITY_EN
  localparam int W = L + 1;
`else
  localparam int W = L;
`endif

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [L-1:0]     func_state_in;
  logic [L-1:0]     func_state_out;
  logic             func_load;
  logic             func_hold;
  logic [CNT_W-1:0] bit_count;
  logic             len_err;
  logic             busy;
`ifdef SCAN_PARITY_EN
  logic             parity_err;
`endif

  scan_chain_target_if sif ();

  scan_chain_target #(.CHAIN_LEN(L)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .scan          (sif),
    .func_state_in (func_state_in),
    .func_state_out(func_state_out),
    .func_load     (func_load),
    .func_hold     (func_hold),
    .bit_count     (bit_count),
    .len_err       (len_err),
`ifdef SCAN_PARITY_EN
    .parity_err    (parity_err),
`endif
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [L-1:0] exp_out;
  logic         exp_len_err;
  logic         exp_par_err;
  logic         last_out;
  int           last_cnt;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word sent by the controller: data plus (parity build) its parity bit,
  // optionally corrupted.
  function automatic logic [W-1:0] mk_din(input logic [L-1:0] d, input bit flip);
`ifdef SCAN_PARITY_EN
    return {(^d) ^ flip, d};
`else
    return (flip ? d : d);
`endif
  endfunction

  task automatic chk_sticky(input string tag);
    chk({tag, "_len_err"}, len_err, exp_len_err);
    chk({tag, "_fso"}, func_state_out, exp_out);
`ifdef SCAN_PARITY_EN
    chk({tag, "_par_err"}, parity_err, exp_par_err);
`endif
  endtask

  // One session: capture cap, then n strobes sending din LSB-first (wrapping),
  // optionally dropping scan_enable in the same cycle as the last strobe.
  task automatic session(input logic [L-1:0] cap, input logic [W-1:0] din,
                         input int n, input bit combine);
    bit           q[$];
    logic [W-1:0] img;
    bit           accepted;
    q = {};
    for (int i = 0; i < L; i++) q.push_back(cap[i]);
`ifdef SCAN_PARITY_EN
    q.push_back(^cap);
`endif
    func_state_in    = cap;
    sif.scan_enable  = 1'b1;
    tick();
    chk("cap_out", sif.scan_output, q[0]);
    chk("cap_cnt", bit_count, 0);
    chk("cap_hold", func_hold, 1);
    chk("cap_busy", busy, 1);
    for (int k = 0; k < n; k++) begin
      sif.scan_ck_enable = 1'b1;
      sif.scan_input     = din[k % W];
      if (combine && k == n - 1) sif.scan_enable = 1'b0;
      void'(q.pop_front());
      q.push_back(din[k % W]);
      tick();
      sif.scan_ck_enable = 1'b0;
      chk("shift_out", sif.scan_output, q[0]);
      chk("shift_cnt", bit_count, k + 1);
    end
    if (!(combine && n > 0)) begin
      sif.scan_enable = 1'b0;
      tick();
    end
    // exit edge has happened: apply the session rules
    accepted = (n == W);
    if (accepted) begin
      for (int i = 0; i < W; i++) img[i] = q[i];
      exp_len_err = 1'b0;
`ifdef SCAN_PARITY_EN
      if (img[L] != ^img[L-1:0]) begin
        accepted    = 1'b0;
        exp_par_err = 1'b1;
      end else begin
        exp_par_err = 1'b0;
      end
`endif
      if (accepted) exp_out = img[L-1:0];
    end else begin
      exp_len_err = 1'b1;
    end
    chk("exit_load", func_load, accepted);
    chk("exit_hold", func_hold, accepted);
    chk_sticky("exit");
    tick();
    chk("post_load", func_load, 0);
    chk("post_hold", func_hold, 0);
    chk("post_busy", busy, 0);
    chk("post_cnt", bit_count, n);
    chk("post_out", sif.scan_output, q[0]);
    last_out = q[0];
    last_cnt = n;
  endtask

  initial begin
    logic [L-1:0] c, d;
    int           n;
    bit           cmb, flip;

    aresetn            = 1'b1;
    sif.scan_enable    = 1'b0;
    sif.scan_ck_enable = 1'b0;
    sif.scan_input     = 1'b0;
    func_state_in      = '0;
    exp_out            = '0;
    exp_len_err        = 1'b0;
    exp_par_err        = 1'b0;
    tick();
    tick();
    chk("rst_out", sif.scan_output, 0);
    chk("rst_cnt", bit_count, 0);
    chk("rst_load", func_load, 0);
    chk("rst_hold", func_hold, 0);
    chk("rst_busy", busy, 0);
    chk_sticky("rst");
    aresetn = 1'b0;
    tick();

    // basic restore: A5 out, 3C in
    session(8'hA5, mk_din(8'h3C, 1'b0), W, 1'b0);
    chk("basic_fso_3c", func_state_out, 8'h3C);

    // short session, then a good one clears len_err
    session(8'hA5, mk_din(8'h77, 1'b0), W - 1, 1'b0);
    chk("short_len_err", len_err, 1);
    session(8'h0F, mk_din(8'h96, 1'b0), W, 1'b0);
    chk("recover_len_err", len_err, 0);

    // last strobe coincides with scan_enable falling
    session(8'h5A, mk_din(8'hC3, 1'b0), W, 1'b1);
    chk("combine_fso", func_state_out, 8'hC3);

    // zero-strobe session
    session(8'hFF, mk_din(8'h00, 1'b0), 0, 1'b0);

    // strobes in IDLE are ignored
    for (int i = 0; i < 4; i++) begin
      sif.scan_ck_enable = 1'b1;
      sif.scan_input     = 1'($urandom);
      tick();
      chk("idle_cnt", bit_count, last_cnt);
      chk("idle_out", sif.scan_output, last_out);
      chk("idle_busy", busy, 0);
    end
    sif.scan_ck_enable = 1'b0;

    // reset mid-session after 4 strobes
    func_state_in   = 8'hE7;
    sif.scan_enable = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      sif.scan_ck_enable = 1'b1;
      sif.scan_input     = 1'b1;
      tick();
    end
    sif.scan_ck_enable = 1'b0;
    #2;
    aresetn = 1'b1;
    #1;
    exp_out     = '0;
    exp_len_err = 1'b0;
    exp_par_err = 1'b0;
    chk("arst_out", sif.scan_output, 0);
    chk("arst_cnt", bit_count, 0);
    chk("arst_load", func_load, 0);
    chk("arst_hold", func_hold, 0);
    chk("arst_busy", busy, 0);
    chk_sticky("arst");
    sif.scan_enable = 1'b0;
    #1;
    aresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_noload", func_load, 0);
    end
    session(8'h81, mk_din(8'h42, 1'b0), W, 1'b0);

`ifdef SCAN_PARITY_EN
    session(8'h3C, mk_din(8'hA5, 1'b1), W, 1'b0);
    chk("par_flip_err", parity_err, 1);
    chk("par_flip_fso", func_state_out, 8'h42);
    session(8'h3C, mk_din(8'hA5, 1'b0), W, 1'b0);
    chk("par_ok_err", parity_err, 0);
`endif

    // randomized sessions
    for (int r = 0; r < 12; r++) begin
      c = L'($urandom);
      d = L'($urandom);
      case ($urandom_range(0, 3))
        0:       n = 0;
        1:       n = W - 1;
        2:       n = W + 1;
        default: n = W;
      endcase
      cmb  = (n > 0) ? 1'($urandom) : 1'b0;
      flip = 1'($urandom_range(0, 3) == 0);
      session(c, mk_din(d, flip), n, cmb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
